// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the RV32I pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // Shadow destination info for an instruction in EX or MEM.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             we;
    logic             ld;
  } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares the ID source registers against one scoreboard entry.
module hazard_match
  import hazard_ctrl_pkg::*;
#(
  parameter bit REQ_LD = 1'b0
) (
  input  sb_entry_t        entry,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  output logic             match_c
);

  // REQ_LD restricts the hit to load producers (the forwarding network covers the rest).
  always_comb begin
    match_c = entry.we && (entry.rd != REG_ZERO) &&
              ((use_rs1 && (rs1 == entry.rd)) || (use_rs2 && (rs2 == entry.rd))) &&
              (!REQ_LD || entry.ld);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble sequencing for the 5-stage RV32I pipeline, with a
// shadow EX/MEM destination scoreboard and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] MODE_NORMAL   = 2'd0;
  localparam logic [1:0] MODE_MEMWAIT  = 2'd1;
  localparam logic [1:0] MODE_REDIRECT = 2'd2;
  localparam logic [1:0] MODE_HAZARD   = 2'd3;

  sb_entry_t        ex_sb_q, ex_sb_d;
  sb_entry_t        mem_sb_q, mem_sb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             ex_hit_c;
  logic             mem_hit_c;
  logic             hit_c;
  logic [1:0]       mode_c;

  hazard_match #(
    .REQ_LD (FWD_EN)
  ) u_ex_match (
    .entry   (ex_sb_q),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .match_c (ex_hit_c)
  );

  hazard_match #(
    .REQ_LD (1'b0)
  ) u_mem_match (
    .entry   (mem_sb_q),
    .rs1     (id_rs1),
    .rs2     (id_rs2),
    .use_rs1 (id_use_rs1),
    .use_rs2 (id_use_rs2),
    .match_c (mem_hit_c)
  );

  // With forwarding, MEM results are always reachable, so only EX loads stall.
  assign hit_c = ex_hit_c || (!FWD_EN && mem_hit_c);

  // Fixed-priority selection of the cycle's sequencing case.
  always_comb begin
    mode_c = MODE_NORMAL;
    if (mem_req && !mem_ack) begin
      mode_c = MODE_MEMWAIT;
    end else if (ex_redirect) begin
      mode_c = MODE_REDIRECT;
    end else if (hit_c) begin
      mode_c = MODE_HAZARD;
    end
  end

  always_comb begin
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;
    ex_sb_d      = ex_sb_q;
    mem_sb_d     = mem_sb_q;
    case (mode_c)
      MODE_MEMWAIT: begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end
      MODE_REDIRECT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        ex_sb_d    = '0;
        mem_sb_d   = ex_sb_q;
      end
      MODE_HAZARD: begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
        ex_sb_d    = '0;
        mem_sb_d   = ex_sb_q;
      end
      default: begin
        ex_sb_d  = '{rd: id_rd, we: id_rf_we, ld: id_is_load};
        mem_sb_d = ex_sb_q;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(ifid_flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_sb_q     <= '0;
      mem_sb_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_sb_q     <= ex_sb_d;
      mem_sb_q    <= mem_sb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (forwarding / no forwarding)
// share stimulus; expectations come from an instruction-level pipeline model.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_rf_we, id_is_load;
  logic       ex_redirect, mem_req, mem_ack;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush;
  logic        a_exmem_stall, a_memwb_bubble;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush;
  logic        b_exmem_stall, b_memwb_bubble;
  logic [3:0]  b_stall_cnt, b_flush_cnt;
  logic [6:0]  a_ctl, b_ctl;

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) u_dut_fwd (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
    .idex_stall(a_idex_stall), .idex_flush(a_idex_flush), .exmem_stall(a_exmem_stall),
    .memwb_bubble(a_memwb_bubble), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(4)) u_dut_nofwd (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
    .idex_stall(b_idex_stall), .idex_flush(b_idex_flush), .exmem_stall(b_exmem_stall),
    .memwb_bubble(b_memwb_bubble), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  assign a_ctl = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_stall, a_idex_flush,
                  a_exmem_stall, a_memwb_bubble};
  assign b_ctl = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_stall, b_idex_flush,
                  b_exmem_stall, b_memwb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vectors: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
  localparam logic [6:0] C_MEMWAIT  = 7'b1101011;
  localparam logic [6:0] C_REDIRECT = 7'b0010100;
  localparam logic [6:0] C_HAZARD   = 7'b1100100;
  localparam logic [6:0] C_NONE     = 7'b0000000;

  typedef struct {
    logic [4:0] rd;
    bit         we;
    bit         ld;
  } instr_t;

  typedef struct {
    logic [6:0]  ctl_a;
    logic [6:0]  ctl_b;
    int unsigned sc_a, fc_a, sc_b, fc_b;
  } exp_t;

  exp_t        exp_q[$];
  instr_t      pipe[2][2];   // [instance][0=EX,1=MEM] instructions that have left ID
  int unsigned m_sc[2];
  int unsigned m_fc[2];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // True when the ID instruction needs the value produced by instruction e.
  function automatic bit needs(instr_t e);
    return e.we && (e.rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == e.rd)) || (id_use_rs2 && (id_rs2 == e.rd)));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 2; s++) pipe[i][s] = '{rd: 5'd0, we: 1'b0, ld: 1'b0};
      m_sc[i] = 0;
      m_fc[i] = 0;
    end
  endfunction

  // Expected controls for instance i this cycle; advances that instance's pipeline.
  function automatic logic [6:0] model_step(int i);
    bit         hz;
    logic [6:0] c;
    instr_t     cur;
    instr_t     nop;
    cur = '{rd: id_rd, we: id_rf_we, ld: id_is_load};
    nop = '{rd: 5'd0, we: 1'b0, ld: 1'b0};
    if (i == 0) hz = pipe[0][0].ld && needs(pipe[0][0]);
    else        hz = needs(pipe[1][0]) || needs(pipe[1][1]);
    if (mem_req && !mem_ack) begin
      c = C_MEMWAIT;
    end else begin
      if (ex_redirect) c = C_REDIRECT;
      else if (hz)     c = C_HAZARD;
      else             c = C_NONE;
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = (c == C_NONE) ? cur : nop;
    end
    if (c[6]) m_sc[i]++;
    if (c[4]) m_fc[i]++;
    return c;
  endfunction

  task automatic cyc(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input bit u1, input bit u2, input bit we, input bit ld,
                     input bit redir, input bit req, input bit ack);
    exp_t e;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; id_rf_we = we; id_is_load = ld;
    ex_redirect = redir; mem_req = req; mem_ack = ack;
    e.sc_a = m_sc[0]; e.fc_a = m_fc[0]; e.sc_b = m_sc[1]; e.fc_b = m_fc[1];
    e.ctl_a = model_step(0);
    e.ctl_b = model_step(1);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: controls are combinational, so the DUT presents a result every driven cycle.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwd_ctl", 32'(a_ctl), 32'(e.ctl_a));
      chk("fwd_stall_cnt", a_stall_cnt, e.sc_a);
      chk("fwd_flush_cnt", a_flush_cnt, e.fc_a);
      chk("nofwd_ctl", 32'(b_ctl), 32'(e.ctl_b));
      chk("nofwd_stall_cnt", 32'(b_stall_cnt), e.sc_b % 16);
      chk("nofwd_flush_cnt", 32'(b_flush_cnt), e.fc_b % 16);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rf_we = 1'b0; id_is_load = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    model_reset();
    #2;
    chk("reset_fwd_ctl", 32'(a_ctl), 32'(C_NONE));
    chk("reset_nofwd_ctl", 32'(b_ctl), 32'(C_NONE));
    chk("reset_fwd_stall_cnt", a_stall_cnt, 32'd0);
    chk("reset_fwd_flush_cnt", a_flush_cnt, 32'd0);
    #10 rst_n = 1'b1;

    // lw x5 ; add x6,x5,x1 held in ID until it issues
    cyc(0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(5, 1, 6, 1, 1, 1, 0, 0, 0, 0);
    idle(3);
    // lw x0 ; add x6,x0,x0
    cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 6, 1, 1, 1, 0, 0, 0, 0);
    idle(3);
    // redirect coincident with a load-use hit, then the same reader again
    cyc(0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    cyc(5, 0, 6, 1, 0, 1, 0, 1, 0, 0);
    cyc(5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    idle(3);
    // memory wait with a pending redirect, then ack
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(3);
    // addi x7 ; sub x8,x7,x2 (back-to-back, then one independent in between)
    cyc(0, 0, 7, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(7, 2, 8, 1, 1, 1, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 7, 1, 0, 1, 0, 0, 0, 0);
    cyc(1, 2, 9, 1, 1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) cyc(7, 2, 8, 1, 1, 1, 0, 0, 0, 0);
    idle(3);

    // randomized traffic over a small register range to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r1, r2, rd;
      bit u1, u2, we, ld, rdr, rq, ak;
      r1  = 5'($urandom_range(0, 3));
      r2  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 3));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      we  = ($urandom_range(0, 3) != 0);
      ld  = ($urandom_range(0, 2) == 0);
      rdr = ($urandom_range(0, 7) == 0);
      rq  = ($urandom_range(0, 3) == 0);
      ak  = 1'($urandom_range(0, 1));
      cyc(r1, r2, rd, u1, u2, we, ld, rdr, rq, ak);
    end

    // asynchronous reset in the middle of a memory wait, after loading x5
    idle(2);
    cyc(0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_fwd_stall_cnt", a_stall_cnt, 32'd0);
    chk("async_fwd_flush_cnt", a_flush_cnt, 32'd0);
    chk("async_nofwd_stall_cnt", 32'(b_stall_cnt), 32'd0);
    chk("async_nofwd_flush_cnt", 32'(b_flush_cnt), 32'd0);
    chk("async_fwd_ctl_memwait", 32'(a_ctl), 32'(C_MEMWAIT));
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; mem_req = 1'b0; ex_redirect = 1'b0;
    #1;
    chk("async_fwd_sb_clear", 32'(a_ctl), 32'(C_NONE));
    chk("async_nofwd_sb_clear", 32'(b_ctl), 32'(C_NONE));
    id_rs1 = '0; id_use_rs1 = 1'b0;
    #1;
    chk("async_fwd_ctl_idle", 32'(a_ctl), 32'(C_NONE));
    chk("async_nofwd_ctl_idle", 32'(b_ctl), 32'(C_NONE));
    model_reset();
    @(negedge clk);
    #3 rst_n = 1'b1;
    cyc(5, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 5, 0, 0, 1, 1, 0, 0, 0);
    cyc(5, 5, 6, 1, 1, 1, 0, 0, 0, 0);
    idle(3);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
